// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered 8-bit arithmetic/logic unit, 16 operations.
//
// Operands and opcode are sampled on the rising clock edge. The result and
// carry flag appear one cycle later and hold until the next edge.
//
// Ports:
//   clock    in   1      rising-edge clock
//   reset    in   1      synchronous, active-low reset (clears both outputs)
//   A        in   WIDTH  operand A, unsigned
//   B        in   WIDTH  operand B, unsigned
//   ALU_Sel  in   4      operation select
//   ALU_Out  out  WIDTH  registered result
//   CarryOut out  1      registered carry, bit WIDTH of A+B for every opcode
//
// Build option:
//   ALU_DIV_EN  defined     -> opcode 3 is the unsigned quotient A/B,
//                              with B==0 returning all ones.
//               not defined -> there is no divider and opcode 3 returns zero.
// ---------------------------------------------------------------------------
module alu #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_Sel,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             CarryOut
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] r_out_p1;
   logic             r_carry_p1;

   // The carry is always taken from the widened sum, whatever the opcode.
   assign w_sum  = {1'b0, A} + {1'b0, B};
   assign w_prod = A * B;

`ifdef ALU_DIV_EN
   // Divide by zero returns all ones so that every opcode has a defined result.
   assign w_quot = (B == '0) ? '1 : (A / B);
`else
   assign w_quot = '0;
`endif

   always_comb begin
      w_result = '0;
      case (ALU_Sel)
         4'h0:    w_result = w_sum[WIDTH-1:0];
         4'h1:    w_result = A - B;
         4'h2:    w_result = w_prod;
         4'h3:    w_result = w_quot;
         4'h4:    w_result = {A[WIDTH-2:0], 1'b0};
         4'h5:    w_result = {1'b0, A[WIDTH-1:1]};
         4'h6:    w_result = {A[WIDTH-2:0], A[WIDTH-1]};
         4'h7:    w_result = {A[0], A[WIDTH-1:1]};
         4'h8:    w_result = A & B;
         4'h9:    w_result = A | B;
         4'hA:    w_result = A ^ B;
         4'hB:    w_result = ~(A | B);
         4'hC:    w_result = ~(A & B);
         4'hD:    w_result = ~(A ^ B);
         4'hE:    w_result = (A > B)  ? WIDTH'(1) : '0;
         4'hF:    w_result = (A == B) ? WIDTH'(1) : '0;
         default: w_result = '0;
      endcase
   end

   // Stage p1: output register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_out_p1   <= '0;
         r_carry_p1 <= 1'b0;
      end else begin
         r_out_p1   <= w_result;
         r_carry_p1 <= w_sum[WIDTH];
      end
   end

   assign ALU_Out  = r_out_p1;
   assign CarryOut = r_carry_p1;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
// Expected results are pushed to a scoreboard queue when the stimulus is
// driven, and they are popped and compared after the capturing clock edge.
// The expectations for opcode 3 follow the ALU_DIV_EN build option.
// ---------------------------------------------------------------------------
module tb_alu;

   logic       clock;
   logic       reset;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] ALU_Sel;
   logic [7:0] ALU_Out;
   logic       CarryOut;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] out;
      logic       c;
      string      tag;
   } exp_t;

   exp_t sb[$];

   alu #(.WIDTH(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .A        (A),
      .B        (B),
      .ALU_Sel  (ALU_Sel),
      .ALU_Out  (ALU_Out),
      .CarryOut (CarryOut)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model, written in integer arithmetic.
   function automatic logic [7:0] model_out(input int a, input int b, input int sel);
      int r;
      r = 0;
      case (sel)
         0:  r = (a + b) % 256;
         1:  r = (a - b + 256) % 256;
         2:  r = (a * b) % 256;
`ifdef ALU_DIV_EN
         3:  r = (b == 0) ? 255 : a / b;
`else
         3:  r = 0;
`endif
         4:  r = (a * 2) % 256;
         5:  r = a / 2;
         6:  r = ((a * 2) % 256) + (a / 128);
         7:  r = (a / 2) + ((a % 2) * 128);
         8:  r = a & b;
         9:  r = a | b;
         10: r = a ^ b;
         11: r = 255 - (a | b);
         12: r = 255 - (a & b);
         13: r = 255 - (a ^ b);
         14: r = (a > b) ? 1 : 0;
         15: r = (a == b) ? 1 : 0;
         default: r = 0;
      endcase
      return 8'(r);
   endfunction

   function automatic logic model_c(input int a, input int b);
      return (a + b) > 255;
   endfunction

   task automatic check_now(input logic [7:0] eo, input logic ec, input string tag);
      checks++;
      assert (ALU_Out === eo) else begin
         errors++;
         $error("FAIL %s out: got %h expected %h", tag, ALU_Out, eo);
      end
      checks++;
      assert (CarryOut === ec) else begin
         errors++;
         $error("FAIL %s carry: got %b expected %b", tag, CarryOut, ec);
      end
   endtask

   // Wait for the capturing edge, then pop the oldest expectation and compare.
   task automatic capture_and_check();
      exp_t e;
      @(posedge clock);
      #1;
      e = sb.pop_front();
      check_now(e.out, e.c, e.tag);
   endtask

   task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                       input logic [7:0] eo, input logic ec, input string tag);
      A = a;
      B = b;
      ALU_Sel = sel;
      sb.push_back('{out: eo, c: ec, tag: tag});
      capture_and_check();
   endtask

   task automatic step_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                             input string tag);
      step(a, b, sel, model_out(int'(a), int'(b), int'(sel)), model_c(int'(a), int'(b)), tag);
   endtask

   initial begin
      reset = 1'b1;
      A = 8'h00;
      B = 8'h00;
      ALU_Sel = 4'h0;
      @(posedge clock);
      #1;

      // Reset overrides an add that would otherwise produce FE with carry.
      reset = 1'b0;
      step(8'hFF, 8'hFF, 4'h0, 8'h00, 1'b0, "reset");
      reset = 1'b1;
      step(8'hFF, 8'hFF, 4'h0, 8'hFE, 1'b1, "post_reset");

      step(8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, "add_wrap");
      step(8'h05, 8'h0A, 4'h1, 8'hFB, 1'b0, "sub_wrap");
      step(8'h10, 8'h10, 4'h2, 8'h00, 1'b0, "mul_low");
`ifdef ALU_DIV_EN
      step(8'h64, 8'h07, 4'h3, 8'h0E, 1'b0, "div");
      step(8'h64, 8'h00, 4'h3, 8'hFF, 1'b0, "div_zero");
`else
      step(8'h64, 8'h07, 4'h3, 8'h00, 1'b0, "div_off");
      step(8'h64, 8'h00, 4'h3, 8'h00, 1'b0, "div_zero_off");
`endif
      step(8'h81, 8'h00, 4'h4, 8'h02, 1'b0, "shl");
      step(8'h81, 8'h00, 4'h5, 8'h40, 1'b0, "shr");
      step(8'h81, 8'h00, 4'h6, 8'h03, 1'b0, "rol");
      step(8'h81, 8'h00, 4'h7, 8'hC0, 1'b0, "ror");
      step(8'hF0, 8'hFF, 4'hC, 8'h0F, 1'b1, "nand");
      step(8'h80, 8'h7F, 4'hE, 8'h01, 1'b0, "gt");
      step(8'h7F, 8'h80, 4'hE, 8'h00, 1'b0, "not_gt");
      step(8'h5A, 8'h5A, 4'hF, 8'h01, 1'b0, "eq");
      step(8'h5A, 8'h5B, 4'hF, 8'h00, 1'b0, "neq");
      step(8'hCC, 8'hAA, 4'h8, 8'h88, 1'b1, "and");
      step(8'hCC, 8'hAA, 4'h9, 8'hEE, 1'b1, "or");
      step(8'hCC, 8'hAA, 4'hA, 8'h66, 1'b1, "xor");
      step(8'hCC, 8'hAA, 4'hB, 8'h11, 1'b1, "nor");
      step(8'hCC, 8'hAA, 4'hD, 8'h99, 1'b1, "xnor");

      // Inputs that change mid-cycle must not reach the outputs before the edge.
      step(8'h11, 8'h22, 4'h0, 8'h33, 1'b0, "lat_first");
      #3;
      A = 8'h40;
      B = 8'hC0;
      ALU_Sel = 4'h2;
      sb.push_back('{out: 8'h00, c: 1'b1, tag: "lat_new"});
      #1;
      check_now(8'h33, 1'b0, "lat_hold");
      capture_and_check();
      // Second edge with the same inputs: the result stays the same.
      @(posedge clock);
      #1;
      check_now(8'h00, 1'b1, "lat_stable");

      // Walk every opcode with pseudo-random operands against the model.
      for (int i = 0; i < 256; i++) begin
         step_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(i % 16), "rand");
      end
      // The operand corners for every opcode.
      for (int s = 0; s < 16; s++) begin
         step_model(8'h00, 8'h00, 4'(s), "corner_00");
         step_model(8'hFF, 8'hFF, 4'(s), "corner_ff");
         step_model(8'h80, 8'h01, 4'(s), "corner_80");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
